serial_rx: RTL and testbench
============================

# serial_rx

Receiver for the idle-level/active-pulse serial clock produced by the team's serial clock transmitter. It synchronises an asynchronous serial clock (`sck`) and data line (`sdi`) into the local `clk` domain, samples `sdi` on each leading edge (idle -> active), assembles `ncyc` bits MSB-first, and presents the word with a one-cycle valid strobe. A stalled frame is aborted by a `clk`-cycle timeout that reports an error.

## Interface
- `P_W`, 32: data word width; valid range 1..32.
- `P_Y_INIT`, 0: reset value of the `sck` synchroniser flops; matches the transmitter's reset output level.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `sck`  in  1  serial clock, asynchronous to `clk`.
- `sdi`  in  1  serial data, asynchronous, MSB first.
- `y0`  in  1  idle level of `sck`; active level is `!y0`.
- `ncyc`  in  8  bits per frame; 0 is treated as 1; values above `P_W` are treated as `P_W`.
- `timeout`  in  32  maximum `clk` cycles spent in S_ACT or S_GAP; 0 disables the timeout.
- `dout`  out  P_W  last good word, right-justified; unused MSBs are 0.
- `dv`  out  1  one-cycle strobe, high when `dout` updates.
- `busy`  out  1  frame in progress (state != S_IDLE).
- `err`  out  1  one-cycle strobe on timeout abort.
- `err_bits`  out  8  bits received before the last abort.

## Operation
- **Synchronisers:**
  - Two flops each on `sck` and `sdi`. The outputs are `sck_s` and `sdi_s`.
  - A third flop `sck_d` holds the previous `sck_s`.
  - `sck` flops reset to `P_Y_INIT`; `sdi` flops reset to 0.
- **Edge definitions:**
  - Leading edge: `sck_d == y0_l && sck_s == !y0_l`.
  - Trailing edge: the reverse transition.
  - `y0_l` follows live `y0` in S_IDLE and is frozen at frame start, so a `y0` change mid-frame is ignored until S_IDLE.
- **State S_IDLE:**
  - On a leading edge: `shreg <= {…0, sdi_s}`, `bit_cnt <= 1`, `tmr <= 0`, go to S_ACT.
  - `sck` held at `!y0` does not start a frame; a true idle-to-active transition is required.
- **State S_ACT (sck active):**
  - On a trailing edge, if `bit_cnt == ncyc_eff`: `dout <= shreg`, `dv <= 1`, go to S_IDLE.
  - On a trailing edge otherwise: `tmr <= 0`, go to S_GAP.
- **State S_GAP (sck idle between bits):**
  - On a leading edge: `shreg <= {shreg[P_W-2:0], sdi_s}`, `bit_cnt++`, `tmr <= 0`, go to S_ACT.
- **Timer:** in S_ACT and S_GAP, `tmr` increments every `clk` cycle that has no edge.
- **Timeout:** if `timeout != 0` and `tmr == timeout-1` with no edge that cycle:
  - pulse `err`, set `err_bits <= bit_cnt`, go to S_IDLE;
  - leave `dout` unchanged.
  - An edge in the same cycle wins over the timeout.
- **Latching:** `ncyc_eff` is computed from `ncyc` and latched at frame start.
- **Outputs:** all outputs are registered. `dv` and `err` are never high together.
- **Unused state encoding:** go to S_IDLE without a `dv`.

## Timing
- **Reset values:** `dout`=0, `dv`=0, `err`=0, `err_bits`=0, `busy`=0, state S_IDLE. Assertion takes effect immediately and abandons any partial frame.
- **Latency:**
  - A pin edge on `sck` is acted on at the 3rd rising `clk` edge after it.
  - `dv` is high for exactly 1 cycle, starting 3 `clk` edges after the final trailing pin edge.
- **Data alignment:** `sdi` goes through the same synchroniser depth as `sck`. `sdi` must be stable at least 2 `clk` periods before and after each leading `sck` edge.
- **Minimum sck pulse:** active and idle phases must each be at least 2 `clk` periods; shorter pulses may be lost.
- **Back-to-back frames:** a leading edge in the first S_IDLE cycle after `dv` is accepted. No dead cycle is required beyond the idle phase.
- **`busy`:**
  - rises in the cycle after the first leading edge is detected;
  - falls in the same cycle that `dv` or `err` asserts.

## Test plan
- **Nominal frame:** `y0`=0, `ncyc`=8, `sck` pattern with 5-`clk` active and idle phases, `sdi`=0xA5 MSB-first -> one `dv` pulse, `dout`=0x000000A5, `err` never high.
- **Inverted idle, full width:** `y0`=1, `ncyc`=32, data 0xDEADBEEF -> `dout`=0xDEADBEEF. Repeat with `ncyc`=40 -> still 32 bits. Repeat with `ncyc`=0 -> 1 bit.
- **Timeout:** `timeout`=20, `ncyc`=8, stop `sck` after 3 bits -> `err` pulse 20 cycles after the last edge, `err_bits`=3, `dout` unchanged, next full frame received correctly.
- **Timeout disabled:** `timeout`=0 with a 1000-cycle stall mid-frame -> no `err`; the frame completes when `sck` resumes.
- **Back-to-back and idle level:** two frames with the leading edge right after `dv` -> two `dv` pulses with correct words. Toggle `y0` mid-frame -> the frame is unaffected.
- **Reset mid-frame:** assert `rst_n`=0 after 4 of 8 bits -> all outputs 0 immediately. After release, a complete frame decodes correctly with no spurious `dv` or `err`.

Source files
------------

// File: rtl/serial_rx.sv
// serial_rx
// Receives frames from an idle-level/active-pulse serial clock. sck and sdi are
// brought into the clk domain through matching two-flop synchronisers. A bit is
// sampled on each leading (idle -> active) sck edge, and bits are assembled
// MSB-first. After ncyc bits the word is presented with a one-cycle dv strobe.
// If a frame stalls for longer than the timeout, it is abandoned with an err
// strobe.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   sck       serial clock (asynchronous)
//   sdi       serial data (asynchronous, MSB first)
//   y0        idle level of sck
//   ncyc      bits per frame (0 -> 1, above P_W -> P_W)
//   timeout   max clk cycles without an edge mid-frame (0 = disabled)
//   dout      last good word, right-justified
//   dv        one-cycle strobe when dout updates
//   busy      frame in progress
//   err       one-cycle strobe on timeout abort
//   err_bits  bits received before the last abort
module serial_rx #(
  parameter int   P_W      = 32,
  parameter logic P_Y_INIT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sck,
  input  logic           sdi,
  input  logic           y0,
  input  logic [7:0]     ncyc,
  input  logic [31:0]    timeout,
  output logic [P_W-1:0] dout,
  output logic           dv,
  output logic           busy,
  output logic           err,
  output logic [7:0]     err_bits
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACT  = 2'b01,
    S_GAP  = 2'b10
  } state_t;

  logic           sck_meta_r, sck_sync_r, sck_d_r;
  logic           sdi_meta_r, sdi_sync_r;
  state_t         state_r, state_nxt;
  logic           y0_frz_r, y0_frz_nxt;
  logic [7:0]     ncyc_eff_r, ncyc_eff_nxt;
  logic [7:0]     bit_cnt_r, bit_cnt_nxt;
  logic [P_W-1:0] shreg_r, shreg_nxt;
  logic [31:0]    tmr_r, tmr_nxt;
  logic [P_W-1:0] dout_r, dout_nxt;
  logic           dv_r, dv_nxt;
  logic           err_r, err_nxt;
  logic [7:0]     err_bits_r, err_bits_nxt;
  logic           busy_r, busy_nxt;

  logic           y0_l_s, lead_s, trail_s, tmo_s;
  logic [7:0]     ncyc_lim_s;
  logic [P_W-1:0] shift_s, first_s;

  // Synchronisers. sdi uses the same depth as sck so data stays aligned with its clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_r <= P_Y_INIT;
      sck_sync_r <= P_Y_INIT;
      sck_d_r    <= P_Y_INIT;
      sdi_meta_r <= 1'b0;
      sdi_sync_r <= 1'b0;
    end else begin
      sck_meta_r <= sck;
      sck_sync_r <= sck_meta_r;
      sck_d_r    <= sck_sync_r;
      sdi_meta_r <= sdi;
      sdi_sync_r <= sdi_meta_r;
    end
  end

  // Edge detection, ncyc clamping, shift-register candidates and timeout compare.
  always_comb begin
    // The idle level tracks y0 only between frames; mid-frame it is frozen.
    y0_l_s  = (state_r == S_IDLE) ? y0 : y0_frz_r;
    lead_s  = (sck_d_r == y0_l_s)  && (sck_sync_r == !y0_l_s);
    trail_s = (sck_d_r == !y0_l_s) && (sck_sync_r == y0_l_s);
    tmo_s   = (timeout != 32'd0) && (tmr_r == (timeout - 32'd1));
    if (ncyc == 8'd0) begin
      ncyc_lim_s = 8'd1;
    end else if (ncyc > 8'(P_W)) begin
      ncyc_lim_s = 8'(P_W);
    end else begin
      ncyc_lim_s = ncyc;
    end
    // Written as a shift plus a bit-0 overwrite so that P_W == 1 needs no special slice.
    shift_s    = shreg_r << 1;
    shift_s[0] = sdi_sync_r;
    first_s    = {P_W{1'b0}};
    first_s[0] = sdi_sync_r;
  end

  // Next-state and output logic of the frame FSM.
  always_comb begin
    state_nxt    = state_r;
    y0_frz_nxt   = y0_frz_r;
    ncyc_eff_nxt = ncyc_eff_r;
    bit_cnt_nxt  = bit_cnt_r;
    shreg_nxt    = shreg_r;
    tmr_nxt      = tmr_r;
    dout_nxt     = dout_r;
    dv_nxt       = 1'b0;
    err_nxt      = 1'b0;
    err_bits_nxt = err_bits_r;
    case (state_r)
      S_IDLE: begin
        if (lead_s) begin
          shreg_nxt    = first_s;
          bit_cnt_nxt  = 8'd1;
          tmr_nxt      = 32'd0;
          ncyc_eff_nxt = ncyc_lim_s;
          y0_frz_nxt   = y0;
          state_nxt    = S_ACT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ACT: begin
        if (trail_s) begin
          if (bit_cnt_r == ncyc_eff_r) begin
            dout_nxt  = shreg_r;
            dv_nxt    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            tmr_nxt   = 32'd0;
            state_nxt = S_GAP;
          end
        end else if (tmo_s) begin
          err_nxt      = 1'b1;
          err_bits_nxt = bit_cnt_r;
          state_nxt    = S_IDLE;
        end else begin
          tmr_nxt = tmr_r + 32'd1;
        end
      end
      S_GAP: begin
        if (lead_s) begin
          shreg_nxt   = shift_s;
          bit_cnt_nxt = bit_cnt_r + 8'd1;
          tmr_nxt     = 32'd0;
          state_nxt   = S_ACT;
        end else if (tmo_s) begin
          err_nxt      = 1'b1;
          err_bits_nxt = bit_cnt_r;
          state_nxt    = S_IDLE;
        end else begin
          tmr_nxt = tmr_r + 32'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      y0_frz_r   <= 1'b0;
      ncyc_eff_r <= 8'd1;
      bit_cnt_r  <= 8'd0;
      shreg_r    <= {P_W{1'b0}};
      tmr_r      <= 32'd0;
      dout_r     <= {P_W{1'b0}};
      dv_r       <= 1'b0;
      err_r      <= 1'b0;
      err_bits_r <= 8'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      y0_frz_r   <= y0_frz_nxt;
      ncyc_eff_r <= ncyc_eff_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      shreg_r    <= shreg_nxt;
      tmr_r      <= tmr_nxt;
      dout_r     <= dout_nxt;
      dv_r       <= dv_nxt;
      err_r      <= err_nxt;
      err_bits_r <= err_bits_nxt;
      busy_r     <= busy_nxt;
    end
  end

  assign dout     = dout_r;
  assign dv       = dv_r;
  assign err      = err_r;
  assign err_bits = err_bits_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx. The stimulus tasks push each expected strobe,
// with its word, bit count and clk cycle, into a queue. A negedge monitor pops
// one entry for every dv/err strobe the DUT shows and compares it.
module tb_serial_rx;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck = 1'b0;
  logic          sdi = 1'b0;
  logic          y0 = 1'b0;
  logic [7:0]    ncyc = 8'd8;
  logic [31:0]   timeout = 32'd0;
  logic [W-1:0]  dout;
  logic          dv, busy, err;
  logic [7:0]    err_bits;

  serial_rx #(.P_W(W), .P_Y_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .y0(y0),
    .ncyc(ncyc), .timeout(timeout), .dout(dout), .dv(dv),
    .busy(busy), .err(err), .err_bits(err_bits)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic [31:0] word;
    logic [7:0]  bits;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        pol = 1'b0;
  logic [31:0] last_good = 32'd0;

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (dv || err)) begin
      n_tests++;
      if (dv && err) begin
        n_fail++;
        $display("FAIL dv_err_overlap dv=%0b err=%0b required not both at cycle %0d", dv, err, cyc);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_strobe dv=%0b err=%0b dout=0x%0h required no strobe at cycle %0d", dv, err, dout, cyc);
      end else begin
        m_e = sb.pop_front();
        if (err !== m_e.is_err || dout !== m_e.word || cyc != m_e.at || busy !== 1'b0 ||
            (m_e.is_err && err_bits !== m_e.bits)) begin
          n_fail++;
          $display("FAIL strobe err=%0b/%0b dout=0x%0h/0x%0h err_bits=%0d/%0d cycle=%0d/%0d busy=%0b/0 (actual/required)",
                   err, m_e.is_err, dout, m_e.word, err_bits, m_e.bits, cyc, m_e.at, busy);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int eff_n(input logic [7:0] n);
    if (n == 8'd0) return 1;
    else if (int'(n) > W) return W;
    else return int'(n);
  endfunction

  function automatic logic [31:0] mask_n(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Send bits first..last of an n-bit word, MSB first; report the cycle of the last trailing edge.
  task automatic drive_bits(input logic [31:0] data, input int n, input int first, input int last,
                            input int act, input int gap, output int trail_at);
    logic [4:0] idx;
    trail_at = cyc;
    for (int i = first; i <= last; i++) begin
      idx = 5'(n - 1 - i);
      sdi = data[idx];
      repeat (gap) @(negedge clk);
      sck = ~pol;
      repeat (act) @(negedge clk);
      sck = pol;
      trail_at = cyc;
    end
  endtask

  task automatic expect_dv(input logic [31:0] data, input int n, input int trail_at);
    exp_t e;
    e.is_err = 1'b0;
    e.word   = data & mask_n(n);
    e.bits   = 8'd0;
    e.at     = trail_at + 3;
    sb.push_back(e);
    last_good = e.word;
  endtask

  task automatic expect_err(input int k, input int edge_at);
    exp_t e;
    e.is_err = 1'b1;
    e.word   = last_good;
    e.bits   = 8'(k);
    e.at     = edge_at + 3 + int'(timeout);
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0 after %0d cycles", sb.size(), k);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] data, input logic [7:0] nc, input int act, input int gap);
    int n, t;
    ncyc = nc;
    n = eff_n(nc);
    drive_bits(data, n, 0, n - 1, act, gap, t);
    expect_dv(data, n, t);
    wait_drain();
  endtask

  // Change the idle level: move y0 first so the sck move is seen as trailing, not leading.
  task automatic set_pol(input logic p);
    if (p != pol) begin
      y0 = p;
      repeat (4) @(negedge clk);
      sck = p;
      pol = p;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, k;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 32'd0);
    chk("rst_dv", {31'd0, dv}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_bits", {24'd0, err_bits}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal frame
    run_frame(32'h0000_00A5, 8'd8, 5, 5);

    // Inverted idle, full width, clamped and zero ncyc
    set_pol(1'b1);
    run_frame(32'hDEAD_BEEF, 8'd32, 3, 3);
    run_frame(32'hDEAD_BEEF, 8'd40, 3, 3);
    run_frame(32'hDEAD_BEEF, 8'd0, 3, 3);

    // Timeout after 3 of 8 bits, then a good frame
    timeout = 32'd20;
    ncyc = 8'd8;
    d = $urandom;
    drive_bits(d, 8, 0, 2, 3, 3, t);
    chk("busy_mid_frame", {31'd0, busy}, 32'd1);
    expect_err(3, t);
    wait_drain();
    chk("err_bits_hold", {24'd0, err_bits}, 32'd3);
    run_frame($urandom, 8'd8, 3, 3);

    // Timeout disabled with a long stall
    timeout = 32'd0;
    ncyc = 8'd8;
    d = $urandom;
    drive_bits(d, 8, 0, 3, 3, 3, t);
    repeat (1000) @(negedge clk);
    chk("busy_after_stall", {31'd0, busy}, 32'd1);
    drive_bits(d, 8, 4, 7, 3, 3, t);
    expect_dv(d, 8, t);
    wait_drain();

    // Back-to-back frames with minimum idle between them
    d = $urandom;
    drive_bits(d, 8, 0, 7, 3, 3, t);
    expect_dv(d, 8, t);
    d = $urandom;
    drive_bits(d, 8, 0, 7, 2, 2, t);
    expect_dv(d, 8, t);
    wait_drain();

    // y0 toggled mid-frame has no effect
    d = $urandom;
    drive_bits(d, 8, 0, 2, 3, 3, t);
    y0 = ~y0;
    drive_bits(d, 8, 3, 7, 3, 3, t);
    expect_dv(d, 8, t);
    wait_drain();
    y0 = pol;
    repeat (4) @(negedge clk);

    // Reset mid-frame
    set_pol(1'b0);
    d = $urandom;
    drive_bits(d, 8, 0, 3, 3, 3, t);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", dout, 32'd0);
    chk("midrst_dv", {31'd0, dv}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_err_bits", {24'd0, err_bits}, 32'd0);
    last_good = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame($urandom, 8'd8, 3, 3);

    // Randomized frames and aborts
    for (int it = 0; it < 24; it++) begin
      set_pol(1'($urandom_range(0, 1)));
      ncyc = 8'($urandom_range(0, 40));
      n = eff_n(ncyc);
      if (n > 1 && $urandom_range(0, 3) == 0) begin
        timeout = 32'($urandom_range(10, 30));
        k = int'($urandom_range(1, n - 1));
        d = $urandom;
        drive_bits(d, n, 0, k - 1, int'($urandom_range(2, 6)), int'($urandom_range(2, 6)), t);
        expect_err(k, t);
        wait_drain();
      end else begin
        timeout = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(30, 60));
        run_frame($urandom, ncyc, int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
